// File: rtl/line_draw_scheduler.sv
// line_draw_scheduler
// Shares one drawline engine and the VGA plot port between two line
// requesters. After reset it can sweep-clear the frame, then it round-robin
// arbitrates pending requests, latches the winner's line, runs the drawline
// start/done handshake and returns a one-cycle ack to the winner.
module line_draw_scheduler #(
    parameter bit         CLEAR_ON_RESET = 1'b1,
    parameter logic [2:0] CLEAR_COLOUR   = 3'b000,
    parameter int         SCREEN_W       = 160,
    parameter int         SCREEN_H       = 120
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [1:0] req,
    input  logic [7:0] r0_x0,
    input  logic [7:0] r0_x1,
    input  logic [6:0] r0_y0,
    input  logic [6:0] r0_y1,
    input  logic [2:0] r0_colour,
    input  logic [7:0] r1_x0,
    input  logic [7:0] r1_x1,
    input  logic [6:0] r1_y0,
    input  logic [6:0] r1_y1,
    input  logic [2:0] r1_colour,
    output logic [1:0] ack,
    output logic       busy,
    output logic       ln_start,
    output logic [7:0] ln_x0,
    output logic [7:0] ln_x1,
    output logic [6:0] ln_y0,
    output logic [6:0] ln_y1,
    output logic [2:0] ln_colour,
    input  logic       ln_done,
    input  logic [7:0] dl_vga_x,
    input  logic [6:0] dl_vga_y,
    input  logic [2:0] dl_vga_colour,
    input  logic       dl_vga_plot,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    typedef enum logic [1:0] {
        S_CLEAR   = 2'd0,
        S_IDLE    = 2'd1,
        S_RUN     = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    localparam state_t     RESET_STATE = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
    localparam logic [7:0] CX_LAST     = 8'(SCREEN_W - 1);
    localparam logic [6:0] CY_LAST     = 7'(SCREEN_H - 1);

    state_t     state_reg;
    state_t     state_next;
    logic [7:0] cx_reg;
    logic [6:0] cy_reg;
    logic       last_grant_reg;
    logic       grant_reg;
    logic       pick_next;
    logic       clear_last;
    logic       ln_start_reg;
    logic [1:0] ack_reg;
    logic [1:0] ack_next;
    logic       busy_reg;
    logic [7:0] ln_x0_reg;
    logic [7:0] ln_x1_reg;
    logic [6:0] ln_y0_reg;
    logic [6:0] ln_y1_reg;
    logic [2:0] ln_colour_reg;

    assign clear_last = (cx_reg == CX_LAST) && (cy_reg == CY_LAST);

    // Tie goes to the requester that did not win last time; otherwise the lone requester.
    assign pick_next = (req == 2'b11) ? ~last_grant_reg : req[1];

    // A requester's ack fires on the edge where its running line reports done.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ack
            assign ack_next[gi] = (state_reg == S_RUN) && ln_done && (grant_reg == 1'(gi));
        end
    endgenerate

    // State register.
    always_ff @(posedge clock) begin
        if (!resetn) state_reg <= RESET_STATE;
        else         state_reg <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_CLEAR:   if (clear_last) state_next = S_IDLE;
            S_IDLE:    if (|req)       state_next = S_RUN;
            S_RUN:     if (ln_done)    state_next = S_RELEASE;
            S_RELEASE: if (!ln_done)   state_next = S_IDLE;
            default:                   state_next = RESET_STATE;
        endcase
    end

    // Clear sweep counters: x fastest, wrapping into y.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            cx_reg <= 8'd0;
            cy_reg <= 7'd0;
        end else if (state_reg == S_CLEAR) begin
            if (cx_reg == CX_LAST) begin
                cx_reg <= 8'd0;
                cy_reg <= (cy_reg == CY_LAST) ? 7'd0 : cy_reg + 7'd1;
            end else begin
                cx_reg <= cx_reg + 8'd1;
            end
        end
    end

    // Grant bookkeeping and latching of the winner's line on the grant cycle.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            last_grant_reg <= 1'b1;
            grant_reg      <= 1'b0;
            ln_x0_reg      <= 8'd0;
            ln_x1_reg      <= 8'd0;
            ln_y0_reg      <= 7'd0;
            ln_y1_reg      <= 7'd0;
            ln_colour_reg  <= 3'd0;
        end else if (state_reg == S_IDLE && (|req)) begin
            last_grant_reg <= pick_next;
            grant_reg      <= pick_next;
            ln_x0_reg      <= pick_next ? r1_x0     : r0_x0;
            ln_x1_reg      <= pick_next ? r1_x1     : r0_x1;
            ln_y0_reg      <= pick_next ? r1_y0     : r0_y0;
            ln_y1_reg      <= pick_next ? r1_y1     : r0_y1;
            ln_colour_reg  <= pick_next ? r1_colour : r0_colour;
        end
    end

    // Handshake and status outputs; start holds while running until done is seen.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            ln_start_reg <= 1'b0;
            ack_reg      <= 2'b00;
            busy_reg     <= CLEAR_ON_RESET;
        end else begin
            ln_start_reg <= (state_reg == S_RUN) && !ln_done;
            ack_reg      <= ack_next;
            busy_reg     <= (state_next != S_IDLE);
        end
    end

    // VGA port: clear sweep, drawline pass-through while running, otherwise no plot.
    always_comb begin
        vga_x      = 8'd0;
        vga_y      = 7'd0;
        vga_colour = 3'd0;
        vga_plot   = 1'b0;
        case (state_reg)
            S_CLEAR: begin
                vga_x      = cx_reg;
                vga_y      = cy_reg;
                vga_colour = CLEAR_COLOUR;
                vga_plot   = 1'b1;
            end
            S_RUN: begin
                vga_x      = dl_vga_x;
                vga_y      = dl_vga_y;
                vga_colour = dl_vga_colour;
                vga_plot   = dl_vga_plot;
            end
            default: ;
        endcase
    end

    assign ln_start  = ln_start_reg;
    assign ack       = ack_reg;
    assign busy      = busy_reg;
    assign ln_x0     = ln_x0_reg;
    assign ln_x1     = ln_x1_reg;
    assign ln_y0     = ln_y0_reg;
    assign ln_y1     = ln_y1_reg;
    assign ln_colour = ln_colour_reg;

endmodule

// File: tb/tb_line_draw_scheduler.sv
// Directed testbench for line_draw_scheduler: clear sweep, single and tied
// requests, held done, reset mid-line and a request pending through the clear.
module tb_line_draw_scheduler;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [1:0] req = 2'b00;
    logic [7:0] r0_x0 = 8'd0, r0_x1 = 8'd0, r1_x0 = 8'd0, r1_x1 = 8'd0;
    logic [6:0] r0_y0 = 7'd0, r0_y1 = 7'd0, r1_y0 = 7'd0, r1_y1 = 7'd0;
    logic [2:0] r0_colour = 3'd0, r1_colour = 3'd0;
    logic [1:0] ack;
    logic       busy, ln_start;
    logic [7:0] ln_x0, ln_x1;
    logic [6:0] ln_y0, ln_y1;
    logic [2:0] ln_colour;
    logic       ln_done = 1'b0;
    logic [7:0] dl_vga_x = 8'd0;
    logic [6:0] dl_vga_y = 7'd0;
    logic [2:0] dl_vga_colour = 3'd0;
    logic       dl_vga_plot = 1'b0;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    int n_checks = 0;
    int n_errors = 0;

    line_draw_scheduler dut (
        .clock(clock), .resetn(resetn), .req(req),
        .r0_x0(r0_x0), .r0_x1(r0_x1), .r0_y0(r0_y0), .r0_y1(r0_y1), .r0_colour(r0_colour),
        .r1_x0(r1_x0), .r1_x1(r1_x1), .r1_y0(r1_y0), .r1_y1(r1_y1), .r1_colour(r1_colour),
        .ack(ack), .busy(busy), .ln_start(ln_start),
        .ln_x0(ln_x0), .ln_x1(ln_x1), .ln_y0(ln_y0), .ln_y1(ln_y1), .ln_colour(ln_colour),
        .ln_done(ln_done),
        .dl_vga_x(dl_vga_x), .dl_vga_y(dl_vga_y), .dl_vga_colour(dl_vga_colour), .dl_vga_plot(dl_vga_plot),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Apply a one-cycle reset and check the state seen right after it.
    task automatic do_reset(input string tag);
        resetn = 1'b0;
        tick();
        check_val({tag, "_ln_start"}, 32'(ln_start), 32'd0);
        check_val({tag, "_ack"}, 32'(ack), 32'd0);
        check_val({tag, "_busy"}, 32'(busy), 32'd1);
        check_val({tag, "_ln_coords"}, {ln_x0, ln_y0, ln_colour, 14'd0}, 32'd0);
        check_val({tag, "_vga_xy_plot"}, {8'd0, vga_x, 1'b0, vga_y, 7'd0, vga_plot}, 32'd1);
        resetn = 1'b1;
    endtask

    // Count the clear sweep from the current sample; optionally raise req1 partway.
    task automatic clear_sweep(input string tag, input bit raise_req1);
        int n = 0;
        int bad = 0;
        logic [7:0] fx = 8'hff, lx = 8'd0;
        logic [6:0] fy = 7'h7f, ly = 7'd0;
        while (vga_plot === 1'b1 && n < 30000) begin
            if (n == 0) begin fx = vga_x; fy = vga_y; end
            lx = vga_x;
            ly = vga_y;
            if (vga_colour !== 3'd0 || ln_start !== 1'b0 || ack !== 2'b00) bad++;
            n++;
            if (raise_req1 && n == 100) begin
                r1_x0 = 8'd5; r1_x1 = 8'd150; r1_y0 = 7'd3; r1_y1 = 7'd110; r1_colour = 3'b010;
                req = 2'b10;
            end
            tick();
        end
        check_val({tag, "_plot_count"}, 32'(n), 32'd19200);
        check_val({tag, "_first_xy"}, {17'd0, fx, fy}, 32'd0);
        check_val({tag, "_last_xy"}, {17'd0, lx, ly}, {17'd0, 8'd159, 7'd119});
        check_val({tag, "_bad_cycles"}, 32'(bad), 32'd0);
        check_val({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    // Play the drawline engine for one granted line and check the handshake.
    task automatic run_line(input string tag, input int idx,
                            input logic [7:0] ex0, input logic [7:0] ex1,
                            input logic [6:0] ey0, input logic [6:0] ey1,
                            input logic [2:0] ec, input int exp_lat,
                            input int done_cycles, input bit drop_req);
        int lat = 0;
        while (ln_start !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        check_val({tag, "_start_latency"}, 32'(lat), 32'(exp_lat));
        check_val({tag, "_ln_x"}, {16'd0, ln_x0, ln_x1}, {16'd0, ex0, ex1});
        check_val({tag, "_ln_y_col"}, {15'd0, ln_y0, ln_y1, ln_colour}, {15'd0, ey0, ey1, ec});
        dl_vga_x = 8'd33 + 8'(idx); dl_vga_y = 7'd44; dl_vga_colour = 3'b101; dl_vga_plot = 1'b1;
        #1;
        check_val({tag, "_vga_pass"}, {13'd0, vga_x, vga_y, vga_colour, vga_plot},
                  {13'd0, 8'd33 + 8'(idx), 7'd44, 3'b101, 1'b1});
        tick(); tick(); tick();
        check_val({tag, "_start_hold"}, {30'd0, ln_start, ack}, 32'h4);
        ln_done = 1'b1;
        tick();
        check_val({tag, "_ack"}, 32'(ack), 32'(1 << idx));
        check_val({tag, "_start_drop_plot"}, {30'd0, ln_start, vga_plot}, 32'd0);
        if (drop_req) req[idx] = 1'b0;
        for (int i = 1; i < done_cycles; i++) begin
            tick();
            check_val({tag, "_release_hold"}, {29'd0, ln_start, ack}, 32'd0);
            check_val({tag, "_release_busy_plot"}, {30'd0, busy, vga_plot}, 32'd2);
        end
        ln_done = 1'b0;
        dl_vga_plot = 1'b0;
    endtask

    initial begin
        // Power-on reset, clear sweep with req1 raised mid-clear.
        do_reset("rst0");
        clear_sweep("clear0", 1'b1);
        check_val("pending_no_start", 32'(ln_start), 32'd0);
        run_line("req1_after_clear", 1, 8'd5, 8'd150, 7'd3, 7'd110, 3'b010, 2, 1, 1'b1);
        tick(); tick();
        check_val("idle_busy", 32'(busy), 32'd0);

        // Both requesters held: grants alternate 0,1,0,1.
        r0_x0 = 8'd10; r0_x1 = 8'd20; r0_y0 = 7'd30; r0_y1 = 7'd40; r0_colour = 3'b001;
        r1_x0 = 8'd159; r1_x1 = 8'd0; r1_y0 = 7'd119; r1_y1 = 7'd0; r1_colour = 3'b111;
        req = 2'b11;
        run_line("tie_a0", 0, 8'd10, 8'd20, 7'd30, 7'd40, 3'b001, 2, 1, 1'b0);
        run_line("tie_b1", 1, 8'd159, 8'd0, 7'd119, 7'd0, 3'b111, 3, 1, 1'b0);
        run_line("tie_c0", 0, 8'd10, 8'd20, 7'd30, 7'd40, 3'b001, 3, 1, 1'b0);
        run_line("tie_d1", 1, 8'd159, 8'd0, 7'd119, 7'd0, 3'b111, 3, 1, 1'b0);
        req = 2'b00;
        tick(); tick(); tick();
        check_val("tie_no_extra_start", {30'd0, ln_start, busy}, 32'd0);

        // req0 alone: red line (80,90)->(60,65).
        r0_x0 = 8'd80; r0_y0 = 7'd90; r0_x1 = 8'd60; r0_y1 = 7'd65; r0_colour = 3'b100;
        req = 2'b01;
        run_line("req0_only", 0, 8'd80, 8'd60, 7'd90, 7'd65, 3'b100, 2, 1, 1'b1);

        // ln_done held 5 extra cycles with req0 still pending; restart only after done falls.
        tick(); tick();
        r0_x0 = 8'd1; r0_x1 = 8'd2; r0_y0 = 7'd3; r0_y1 = 7'd4; r0_colour = 3'b011;
        req = 2'b01;
        run_line("done_hold", 0, 8'd1, 8'd2, 7'd3, 7'd4, 3'b011, 2, 6, 1'b0);
        run_line("after_hold", 0, 8'd1, 8'd2, 7'd3, 7'd4, 3'b011, 3, 1, 1'b1);

        // Reset in the middle of a line.
        tick(); tick();
        r1_x0 = 8'd7; r1_x1 = 8'd8; r1_y0 = 7'd9; r1_y1 = 7'd10; r1_colour = 3'b110;
        req = 2'b10;
        tick(); tick();
        check_val("pre_reset_running", 32'(ln_start), 32'd1);
        req = 2'b00;
        do_reset("rst_mid");
        clear_sweep("clear1", 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
